// File: rtl/pt_walker_sv.sv
// pt_walker_sv: hardware page-table walker (Sv39 with LEVELS=3, Sv48 with LEVELS=4).
// Takes one VA per request, walks the tables from ptbr by fetching each PTE as a full cache
// line over the arbitrated main bus, and returns one PA together with fault and level status.
// Optional feature: define PTW_LASTHIT_EN to keep the last non-faulting translation in a
// one-entry register so a repeated VPN under the same ptbr completes without bus traffic.
`timescale 1ns/1ps

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module pt_walker_sv #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LEVELS         = 3,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               ptbr,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [63:0]               req_va,
  output logic                      resp_valid,
  output logic [63:0]               resp_pa,
  output logic                      resp_fault,
  output logic [1:0]                resp_level,
  output logic                      abtr_reqcyc,
  input  logic                      abtr_grant,
  output logic                      bus_busy,
  output logic                      main_bus_reqcyc,
  output logic [63:0]               main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
  input  logic                      main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
  output logic                      main_bus_respack
);

  localparam int VA_WIDTH = 12 + 9 * LEVELS;
  localparam int BEAT_W   = $clog2(LINE_BEATS);
  localparam logic [63:0] LINE_MASK = 64'(LINE_BEATS * 8 - 1);
  localparam logic [1:0]  TOP_LVL   = 2'(LEVELS - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG =
    (BUS_TAG_WIDTH'(`SYSBUS_READ) << 12) | (BUS_TAG_WIDTH'(`SYSBUS_MEMORY) << 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_WAIT,
    S_BEAT,
    S_CHECK,
    S_DONE
  } state_t;

  // Byte offset of the PTE selected by the VPN field of a given level.
  function automatic logic [63:0] vpn_off(input logic [63:0] va, input logic [1:0] lvl);
    logic [8:0] idx;
    idx = va[12 + 9 * int'(lvl) +: 9];
    return {52'd0, idx, 3'd0};
  endfunction

  // Mask of the page-offset bits for a leaf found at the given level.
  function automatic logic [63:0] page_mask(input logic [1:0] lvl);
    return (64'd1 << (12 + 9 * int'(lvl))) - 64'd1;
  endfunction

  state_t                     state_q, state_d;
  logic [1:0]                 lvl_q, lvl_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [63:0]                va_q, va_d;
  logic [63:0]                addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0]  pte_q, pte_d;

  logic                       req_ready_q, req_ready_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [63:0]                resp_pa_q, resp_pa_d;
  logic                       resp_fault_q, resp_fault_d;
  logic [1:0]                 resp_level_q, resp_level_d;
  logic                       abtr_reqcyc_q, abtr_reqcyc_d;
  logic                       bus_busy_q, bus_busy_d;
  logic                       reqcyc_q, reqcyc_d;
  logic [63:0]                req_addr_q, req_addr_d;
  logic [BUS_TAG_WIDTH-1:0]   reqtag_q, reqtag_d;

  logic                       beat_hit;
  logic [BEAT_W-1:0]          sel_beat;
  logic                       va_canon;
  logic                       pte_v, pte_r, pte_w, pte_x;
  logic [63:0]                ppn_base;
  logic [63:0]                cur_mask;
  logic [63:0]                leaf_pa;
  logic                       misaligned;
  logic                       unused_pte_bits;

`ifdef PTW_LASTHIT_EN
  logic                       lh_valid_q, lh_valid_d;
  logic [63:0]                lh_va_q, lh_va_d;
  logic [63:0]                lh_ptbr_q, lh_ptbr_d;
  logic [63:0]                lh_pa_q, lh_pa_d;
  logic [1:0]                 lh_lvl_q, lh_lvl_d;
  logic [63:0]                walk_ptbr_q, walk_ptbr_d;
  logic [63:0]                ptbr_prev_q;
  logic [63:0]                lh_mask;
  logic                       lh_hit;
`endif

  // Only beats carrying our read tag belong to this walk; they are acked as they arrive.
  assign beat_hit = (state_q == S_WAIT || state_q == S_BEAT) && main_bus_respcyc &&
                    (main_bus_resptag == READ_TAG);
  assign main_bus_respack = beat_hit;

  assign sel_beat = addr_q[BEAT_W+2:3];
  assign va_canon = (req_va[63:VA_WIDTH] == {(64 - VA_WIDTH){req_va[VA_WIDTH-1]}});

  assign pte_v      = pte_q[0];
  assign pte_r      = pte_q[1];
  assign pte_w      = pte_q[2];
  assign pte_x      = pte_q[3];
  assign ppn_base   = {8'd0, pte_q[53:10], 12'd0};
  assign cur_mask   = page_mask(lvl_q);
  // A superpage leaf must have its PPN bits below the leaf level cleared.
  assign misaligned = |(ppn_base & cur_mask);
  assign leaf_pa    = (ppn_base & ~cur_mask) | (va_q & cur_mask);
  assign unused_pte_bits = ^{pte_q[BUS_DATA_WIDTH-1:54], pte_q[9:4]};

`ifdef PTW_LASTHIT_EN
  assign lh_mask = page_mask(lh_lvl_q);
  assign lh_hit  = lh_valid_q && (ptbr == lh_ptbr_q) && ((req_va & ~lh_mask) == lh_va_q);
`endif

  // Next-state, next-result and registered-output computation for the walk FSM.
  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    beat_d       = beat_q;
    va_d         = va_q;
    addr_d       = addr_q;
    pte_d        = pte_q;
    resp_pa_d    = resp_pa_q;
    resp_fault_d = resp_fault_q;
    resp_level_d = resp_level_q;
`ifdef PTW_LASTHIT_EN
    lh_valid_d   = lh_valid_q;
    lh_va_d      = lh_va_q;
    lh_ptbr_d    = lh_ptbr_q;
    lh_pa_d      = lh_pa_q;
    lh_lvl_d     = lh_lvl_q;
    walk_ptbr_d  = walk_ptbr_q;
    if (ptbr != ptbr_prev_q) lh_valid_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          va_d         = req_va;
          lvl_d        = TOP_LVL;
          beat_d       = '0;
          addr_d       = ptbr + vpn_off(req_va, TOP_LVL);
          resp_pa_d    = '0;
          resp_fault_d = 1'b0;
          resp_level_d = '0;
`ifdef PTW_LASTHIT_EN
          walk_ptbr_d  = ptbr;
`endif
          if (!va_canon) begin
            state_d      = S_DONE;
            resp_fault_d = 1'b1;
            resp_level_d = TOP_LVL;
          end
`ifdef PTW_LASTHIT_EN
          else if (lh_hit) begin
            state_d      = S_DONE;
            resp_pa_d    = lh_pa_q | (req_va & lh_mask);
            resp_level_d = lh_lvl_q;
          end
`endif
          else begin
            state_d = S_ARB;
          end
        end
      end
      S_ARB: begin
        if (abtr_grant) state_d = S_REQ;
      end
      S_REQ: begin
        beat_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT, S_BEAT: begin
        if (beat_hit) begin
          if (beat_q == sel_beat) pte_d = main_bus_resp;
          if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
            state_d = S_CHECK;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_BEAT;
          end
        end
      end
      S_CHECK: begin
        if (!pte_v || (!pte_r && pte_w) ||
            ((pte_r || pte_x) && misaligned) ||
            (!pte_r && !pte_x && lvl_q == 2'd0)) begin
          state_d      = S_DONE;
          resp_fault_d = 1'b1;
          resp_pa_d    = '0;
          resp_level_d = lvl_q;
        end else if (pte_r || pte_x) begin
          state_d      = S_DONE;
          resp_fault_d = 1'b0;
          resp_pa_d    = leaf_pa;
          resp_level_d = lvl_q;
`ifdef PTW_LASTHIT_EN
          lh_valid_d   = (ptbr == ptbr_prev_q);
          lh_va_d      = va_q & ~cur_mask;
          lh_ptbr_d    = walk_ptbr_q;
          lh_pa_d      = leaf_pa & ~cur_mask;
          lh_lvl_d     = lvl_q;
`endif
        end else begin
          lvl_d   = lvl_q - 2'd1;
          addr_d  = ppn_base + vpn_off(va_q, lvl_q - 2'd1);
          state_d = S_ARB;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d   = (state_d == S_IDLE);
    resp_valid_d  = (state_d == S_DONE);
    abtr_reqcyc_d = (state_d == S_ARB);
    bus_busy_d    = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_BEAT);
    reqcyc_d      = (state_d == S_REQ);
    req_addr_d    = (state_d == S_REQ) ? (addr_d & ~LINE_MASK) : 64'd0;
    reqtag_d      = (state_d == S_REQ) ? READ_TAG : '0;
  end

  // FSM state, walk level, beat counter, result and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      lvl_q         <= '0;
      beat_q        <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_pa_q     <= '0;
      resp_fault_q  <= 1'b0;
      resp_level_q  <= '0;
      abtr_reqcyc_q <= 1'b0;
      bus_busy_q    <= 1'b0;
      reqcyc_q      <= 1'b0;
      req_addr_q    <= '0;
      reqtag_q      <= '0;
    end else begin
      state_q       <= state_d;
      lvl_q         <= lvl_d;
      beat_q        <= beat_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_pa_q     <= resp_pa_d;
      resp_fault_q  <= resp_fault_d;
      resp_level_q  <= resp_level_d;
      abtr_reqcyc_q <= abtr_reqcyc_d;
      bus_busy_q    <= bus_busy_d;
      reqcyc_q      <= reqcyc_d;
      req_addr_q    <= req_addr_d;
      reqtag_q      <= reqtag_d;
    end
  end

  // Walk datapath: latched VA, current PTE address and selected PTE (no reset needed).
  always_ff @(posedge clk) begin
    va_q   <= va_d;
    addr_q <= addr_d;
    pte_q  <= pte_d;
  end

`ifdef PTW_LASTHIT_EN
  // Last-hit entry; invalidated on reset and whenever ptbr changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lh_valid_q  <= 1'b0;
      lh_va_q     <= '0;
      lh_ptbr_q   <= '0;
      lh_pa_q     <= '0;
      lh_lvl_q    <= '0;
      walk_ptbr_q <= '0;
      ptbr_prev_q <= '0;
    end else begin
      lh_valid_q  <= lh_valid_d;
      lh_va_q     <= lh_va_d;
      lh_ptbr_q   <= lh_ptbr_d;
      lh_pa_q     <= lh_pa_d;
      lh_lvl_q    <= lh_lvl_d;
      walk_ptbr_q <= walk_ptbr_d;
      ptbr_prev_q <= ptbr;
    end
  end
`endif

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_pa         = resp_pa_q;
  assign resp_fault      = resp_fault_q;
  assign resp_level      = resp_level_q;
  assign abtr_reqcyc     = abtr_reqcyc_q;
  assign bus_busy        = bus_busy_q;
  assign main_bus_reqcyc = reqcyc_q;
  assign main_bus_req    = req_addr_q;
  assign main_bus_reqtag = reqtag_q;

endmodule

// File: tb/tb_pt_walker_sv.sv
// tb_pt_walker_sv: directed, table-driven bench for pt_walker_sv (Sv39, 8-beat lines),
// with a sparse memory model answering line bursts and hand-written reset/abort sequences.
`timescale 1ns/1ps

module tb_pt_walker_sv;

  localparam int          LB   = 8;
  localparam logic [12:0] RTAG = 13'h1100;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ptbr;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_va;
  logic        resp_valid;
  logic [63:0] resp_pa;
  logic        resp_fault;
  logic [1:0]  resp_level;
  logic        abtr_reqcyc;
  logic        abtr_grant;
  logic        bus_busy;
  logic        main_bus_reqcyc;
  logic [63:0] main_bus_req;
  logic [12:0] main_bus_reqtag;
  logic        main_bus_respcyc;
  logic [63:0] main_bus_resp;
  logic [12:0] main_bus_resptag;
  logic        main_bus_respack;

  always #5 clk = ~clk;

  pt_walker_sv #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .LEVELS        (3),
    .LINE_BEATS    (LB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ptbr            (ptbr),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_va          (req_va),
    .resp_valid      (resp_valid),
    .resp_pa         (resp_pa),
    .resp_fault      (resp_fault),
    .resp_level      (resp_level),
    .abtr_reqcyc     (abtr_reqcyc),
    .abtr_grant      (abtr_grant),
    .bus_busy        (bus_busy),
    .main_bus_reqcyc (main_bus_reqcyc),
    .main_bus_req    (main_bus_req),
    .main_bus_reqtag (main_bus_reqtag),
    .main_bus_respcyc(main_bus_respcyc),
    .main_bus_resp   (main_bus_resp),
    .main_bus_resptag(main_bus_resptag),
    .main_bus_respack(main_bus_respack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem [logic [63:0]];
  bit          interleave = 1'b0;
  bit          bus_seen   = 1'b0;
  bit          tag_bad    = 1'b0;

  typedef struct {
    logic [63:0]      ptbr;
    logic [63:0]      va;
    int               np;
    logic [2:0][63:0] a;
    logic [2:0][63:0] d;
    bit               ilv;
    logic [63:0]      exp_pa;
    bit               exp_fault;
    logic [1:0]       exp_lvl;
    bit               exp_bus;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic vec_t mk(input logic [63:0] p, input logic [63:0] va, input int np,
                              input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2,
                              input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                              input bit ilv, input logic [63:0] pa, input bit f,
                              input logic [1:0] l, input bit bus);
    vec_t v;
    v.ptbr = p; v.va = va; v.np = np;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.ilv = ilv; v.exp_pa = pa; v.exp_fault = f; v.exp_lvl = l; v.exp_bus = bus;
    return v;
  endfunction

  // Memory responder: grants arbitration, captures the line request, returns LB beats.
  initial begin : responder
    logic [63:0] line;
    int          lat;
    int          bi;
    int          phase;
    bit          tog;
    abtr_grant       = 1'b0;
    main_bus_respcyc = 1'b0;
    main_bus_resp    = '0;
    main_bus_resptag = '0;
    line = '0; lat = 0; bi = 0; phase = 0; tog = 1'b0;
    forever begin
      @(negedge clk);
      abtr_grant       = 1'b0;
      main_bus_respcyc = 1'b0;
      main_bus_resp    = '0;
      main_bus_resptag = '0;
      if (!reset) begin
        phase = 0;
        continue;
      end
      abtr_grant = abtr_reqcyc;
      if (main_bus_reqcyc) begin
        bus_seen = 1'b1;
        if (main_bus_reqtag !== RTAG || main_bus_req[5:0] !== 6'd0) tag_bad = 1'b1;
      end
      case (phase)
        0: begin
          if (main_bus_reqcyc) begin
            line = main_bus_req; lat = 2; bi = 0; tog = interleave; phase = 1;
          end
        end
        1: begin
          lat--;
          if (lat == 0) phase = 2;
        end
        default: begin
          main_bus_respcyc = 1'b1;
          if (tog) begin
            main_bus_resptag = 13'h0155;
            main_bus_resp    = 64'h0000_0000_3FFF_FC0F;
            tog = 1'b0;
            #1 chk("foreign_beat_ack", main_bus_respack, 64'd0);
          end else begin
            main_bus_resptag = RTAG;
            main_bus_resp    = mem_rd(line + 64'(8 * bi));
            #1 chk("own_beat_ack", main_bus_respack, 64'd1);
            bi++;
            tog = interleave;
            if (bi == LB) phase = 0;
          end
        end
      endcase
    end
  end

  task automatic load_mem(input vec_t v);
    mem.delete();
    for (int k = 0; k < v.np; k++)
      for (int i = 0; i < LB; i++)
        mem[(v.a[k] & ~64'h3F) + 64'(8 * i)] = 64'h3400_000F + 64'(i << 10);
    for (int k = 0; k < v.np; k++) mem[v.a[k]] = v.d[k];
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit got;
    load_mem(v);
    interleave = v.ilv;
    bus_seen   = 1'b0;
    tag_bad    = 1'b0;
    @(negedge clk);
    ptbr = v.ptbr; req_va = v.va; req_valid = 1'b1;
    chk($sformatf("v%0d_req_ready", idx), req_ready, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_va    = 64'hFFFF_0000_DEAD_0000;
    cyc = 1;
    got = resp_valid;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      got = resp_valid;
    end
    chk($sformatf("v%0d_resp_seen", idx), got, 64'd1);
    if (got) begin
      chk($sformatf("v%0d_pa", idx), resp_pa, v.exp_pa);
      chk($sformatf("v%0d_fault", idx), resp_fault, v.exp_fault);
      chk($sformatf("v%0d_level", idx), resp_level, v.exp_lvl);
      @(negedge clk);
      chk($sformatf("v%0d_valid_pulse", idx), resp_valid, 64'd0);
      chk($sformatf("v%0d_pa_held", idx), resp_pa, v.exp_pa);
    end
    chk($sformatf("v%0d_bus_used", idx), bus_seen, v.exp_bus);
    chk($sformatf("v%0d_req_tag_align", idx), tag_bad, 64'd0);
    if (!v.exp_bus) chk($sformatf("v%0d_fast_fault", idx), (cyc <= 2), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    reset = 1'b0; ptbr = '0; req_valid = 1'b0; req_va = '0;

    //           ptbr           va                      np a0            a1            a2            d0            d1            d2            ilv pa             f  lvl bus
    vecs[0]  = mk(64'h1000,     64'hFFFF_FFC0_2030_1ABC, 3, 64'h1800,     64'h2808,     64'h3808,     64'h801,      64'hC01,      64'h2004_8C0F, 0, 64'h8012_3ABC, 0, 0, 1);
    vecs[1]  = mk(64'h1000,     64'hFFFF_FFC0_2030_1ABC, 3, 64'h1800,     64'h2808,     64'h3808,     64'h801,      64'hC01,      64'h2004_8C0F, 1, 64'h8012_3ABC, 0, 0, 1);
    vecs[2]  = mk(64'h1000,     64'h4061_2345,           2, 64'h1008,     64'h5018,     64'h0,        64'h1401,     64'h2008_0003, 64'h0,        0, 64'h8021_2345, 0, 1, 1);
    vecs[3]  = mk(64'h1000,     64'h4061_2345,           2, 64'h1008,     64'h5018,     64'h0,        64'h1401,     64'h2008_0403, 64'h0,        0, 64'h0,         1, 1, 1);
    vecs[4]  = mk(64'h1000,     64'h0000_0080_0000_0000, 0, 64'h0,        64'h0,        64'h0,        64'h0,        64'h0,        64'h0,         0, 64'h0,         1, 2, 0);
    vecs[5]  = mk(64'h1000,     64'h0000_0040_2030_1ABC, 0, 64'h0,        64'h0,        64'h0,        64'h0,        64'h0,        64'h0,         0, 64'h0,         1, 2, 0);
    vecs[6]  = mk(64'h1000,     64'h0000_0000_0000_1000, 0, 64'h0,        64'h0,        64'h0,        64'h0,        64'h0,        64'h0,         0, 64'h0,         1, 2, 1);
    vecs[7]  = mk(64'h1000,     64'h4061_2345,           2, 64'h1008,     64'h5018,     64'h0,        64'h1401,     64'h2008_0005, 64'h0,        0, 64'h0,         1, 1, 1);
    vecs[8]  = mk(64'h1000,     64'hFFFF_FFC0_2030_1ABC, 3, 64'h1800,     64'h2808,     64'h3808,     64'h801,      64'hC01,      64'h801,       0, 64'h0,         1, 0, 1);
    vecs[9]  = mk(64'h1000,     64'h1234_5678,           1, 64'h1000,     64'h0,        64'h0,        64'h1000_000B, 64'h0,       64'h0,         0, 64'h5234_5678, 0, 2, 1);
    vecs[10] = mk(64'h8000_0000, 64'h1234_5678,          1, 64'h8000_0000, 64'h0,       64'h0,        64'h1000_040B, 64'h0,       64'h0,         0, 64'h0,         1, 2, 1);

    // Reset state while reset is held low.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 64'd1);
    chk("rst_resp_valid", resp_valid, 64'd0);
    chk("rst_resp_pa", resp_pa, 64'd0);
    chk("rst_resp_fault", resp_fault, 64'd0);
    chk("rst_resp_level", resp_level, 64'd0);
    chk("rst_abtr_reqcyc", abtr_reqcyc, 64'd0);
    chk("rst_bus_busy", bus_busy, 64'd0);
    chk("rst_reqcyc", main_bus_reqcyc, 64'd0);
    chk("rst_req", main_bus_req, 64'd0);
    chk("rst_reqtag", main_bus_reqtag, 64'd0);
    chk("rst_respack", main_bus_respack, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset asserted while waiting for the burst: walk aborts at once.
    load_mem(vecs[0]);
    interleave = 1'b0;
    @(negedge clk);
    ptbr = vecs[0].ptbr; req_va = vecs[0].va; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!main_bus_reqcyc && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_req", main_bus_reqcyc, 64'd1);
    @(posedge clk);
    #1 chk("abort_busy_in_wait", bus_busy, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 64'd1);
    chk("abort_bus_busy", bus_busy, 64'd0);
    chk("abort_reqcyc", main_bus_reqcyc, 64'd0);
    chk("abort_abtr", abtr_reqcyc, 64'd0);
    chk("abort_resp_valid", resp_valid, 64'd0);
    chk("abort_respack", main_bus_respack, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
